// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column widths, GF(2^8) xtime and the
// MixColumns engine FSM encoding.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward MixColumns on one 32-bit column; row 0 byte sits in bits [31:24].
module mix_column_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign {a0, a1, a2, a3} = col_in;

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3*a is folded in as xtime(a)^a
    assign col_out[31:24] = x0 ^ x1 ^ a1 ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ x1 ^ x2 ^ a2 ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ x3 ^ a3;
    assign col_out[7:0]   = x0 ^ a0 ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative forward MixColumns: transforms COLS_PER_CYCLE columns of the
// held state per clock, with valid/ready on both sides.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

    mc_state_e          fsm_q, fsm_d;
    logic [1:0]         col_cnt_q, col_cnt_d;
    logic [STATE_W-1:0] data_q, data_d;

    logic [1:0]       col_idx [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_idx[k] = col_cnt_q + 2'(k);
        assign col_in[k]  = data_q[col_idx[k]*COL_W +: COL_W];

        mix_column_word u_word (
            .col_in  (col_in[k]),
            .col_out (col_out[k])
        );
    end

    always_comb begin
        fsm_d     = fsm_q;
        col_cnt_d = col_cnt_q;
        data_d    = data_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    fsm_d     = BUSY;
                    data_d    = state_in;
                    col_cnt_d = '0;
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    data_d[col_idx[k]*COL_W +: COL_W] = col_out[k];
                end
                col_cnt_d = col_cnt_q + CNT_STEP;
                if (col_cnt_q == LAST_GRP) fsm_d = DONE;
            end
            DONE: begin
                // back-to-back: reload in the same cycle the result leaves
                if (out_ready) begin
                    if (in_valid) begin
                        fsm_d     = BUSY;
                        data_d    = state_in;
                        col_cnt_d = '0;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            col_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            fsm_q     <= fsm_d;
            col_cnt_q <= col_cnt_d;
            data_q    <= data_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
    assign out_valid = (fsm_q == DONE);
    assign state_out = out_valid ? data_q : '0;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one instance each of 1, 2 and 4 columns/cycle,
// checked against a GF(2^8) matrix model.
module tb_mix_columns_seq;

    localparam logic [31:0] FWD = 32'h02030101;
    localparam logic [31:0] INV = 32'h0e0b0d09;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] sin  [3];
    logic [127:0] sout [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .state_in  (sin[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .state_out (sout[g])
        );
    end

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // circulant matrix product; coef[31:24] is the diagonal coefficient
    function automatic logic [127:0] mix_ref(input logic [127:0] s,
                                             input logic [31:0] coef);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        int           off;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    off = (k - r + 4) % 4;
                    acc = acc ^ gmul(coef[31-8*off -: 8],
                                     s[c*32+24-8*k +: 8]);
                end
                o[c*32+24-8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input bit ok, input string nm,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_out(input int d, output int n);
        n = 0;
        while (!ov[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_one(input int d, input logic [127:0] din,
                           input logic [127:0] exp, input string nm);
        int n;
        @(negedge clk);
        ordy[d] = 1'b1;
        iv[d]   = 1'b1;
        sin[d]  = din;
        @(posedge clk);
        #1;
        iv[d]  = 1'b0;
        sin[d] = rnd128();
        wait_out(d, n);
        check(n == (4 >> d), {nm, "_lat"}, 128'(n), 128'(4 >> d));
        check(sout[d] == exp, {nm, "_data"}, sout[d], exp);
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int d, input int n);
        logic [127:0] q[$];
        logic [127:0] cur, orig, exp;
        int  sent = 0;
        int  got  = 0;
        int  cyc  = 0;
        bit  ai, ao;
        cur = rnd128();
        while (got < n && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            iv[d]   = (sent < n) && ($urandom_range(9) < 7);
            ordy[d] = ($urandom_range(9) < 6);
            sin[d]  = iv[d] ? cur : rnd128();
            #4;
            ai = iv[d] && ir[d];
            ao = ov[d] && ordy[d];
            if (ao) begin
                if (q.size() == 0) begin
                    check(1'b0, "rand_spurious", sout[d], '0);
                end else begin
                    orig = q.pop_front();
                    exp  = mix_ref(orig, FWD);
                    check(sout[d] == exp, "rand_mix", sout[d], exp);
                    check(mix_ref(sout[d], INV) == orig, "round_trip",
                          mix_ref(sout[d], INV), orig);
                end
                got++;
            end
            if (ai) begin
                q.push_back(cur);
                cur = rnd128();
                sent++;
            end
        end
        if (got < n) check(1'b0, "rand_timeout", 128'(got), 128'(n));
        @(negedge clk);
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int           n;
        logic [127:0] v1, v2, e1, e2;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
            sin[d]  = '0;
        end

        tbl[0].din  = 128'hdb135345_f20a225c_01010101_2d26314c;
        tbl[0].dout = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
        tbl[1].din  = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
        tbl[1].dout = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;
        for (int i = 2; i < 4; i++) begin
            tbl[i].din  = rnd128();
            tbl[i].dout = mix_ref(tbl[i].din, FWD);
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check(ov[d] == 1'b0, "rst_out_valid", 128'(ov[d]), 128'd0);
            check(sout[d] == '0, "rst_state_out", sout[d], '0);
            check(ir[d] == 1'b1, "rst_in_ready", 128'(ir[d]), 128'd1);
        end

        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 3; d++) begin
                run_one(d, tbl[i].din, tbl[i].dout, "tbl");
            end
        end

        // backpressure in DONE, then back-to-back reload
        v1 = rnd128();
        v2 = rnd128();
        e1 = mix_ref(v1, FWD);
        e2 = mix_ref(v2, FWD);
        @(negedge clk);
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        sin[0]  = v1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        wait_out(0, n);
        check(n == 4, "bp_lat", 128'(n), 128'd4);
        repeat (10) begin
            @(posedge clk);
            #1;
            check(ov[0] && !ir[0] && sout[0] == e1, "bp_hold", sout[0], e1);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        sin[0]  = v2;
        #1;
        check(ir[0] == 1'b1, "bp_ready", 128'(ir[0]), 128'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        check(ov[0] == 1'b0, "bp_released", 128'(ov[0]), 128'd0);
        wait_out(0, n);
        check(n == 4, "bp_b2b_lat", 128'(n), 128'd4);
        check(sout[0] == e2, "bp_b2b_data", sout[0], e2);
        @(posedge clk);
        #1;

        // reset with dut0 in its 2nd BUSY cycle and dut2 parked in DONE
        @(negedge clk);
        ordy[2] = 1'b0;
        iv[0]   = 1'b1;
        iv[2]   = 1'b1;
        sin[0]  = v1;
        sin[2]  = v1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        iv[2] = 1'b0;
        @(posedge clk);
        #1;
        check(ov[2] == 1'b1, "rst_pre_done", 128'(ov[2]), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check(ov[d] == 1'b0 && sout[d] == '0, "rst_async",
                  sout[d], '0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[2] = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            check(!ov[0] && !ov[1] && !ov[2], "rst_no_emit",
                  128'({ov[2], ov[1], ov[0]}), '0);
        end
        for (int d = 0; d < 3; d++) begin
            run_one(d, tbl[1].din, tbl[1].dout, "post_rst");
        end

        random_run(0, 340);
        random_run(1, 330);
        random_run(2, 330);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
